l2_mem_arbiter: RTL and testbench

- Shares one 128-bit line-wide memory port between the unified L2 cache's D-side miss/writeback port and its I-side fill port.
- Arbitrates, registers the winning request, drives memory until it reports ready, then returns a one-cycle ready pulse and held read data to the winner.
- Sits between the L2 (D_mem_*/I_mem_* side) and main memory.

---
 rtl/l2_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_l2_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_mem_arbiter.sv
// ------------------------------------------------------------------
// l2_mem_arbiter: shares one line-wide memory port between the L2
// D-side and I-side. Optional perf counters: L2_ARB_PERF_CNT_EN. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module l2_mem_arbiter #(
  parameter int ADDR_W     = 28,
  parameter int LINE_W     = 128,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              D_mem_read,
  input  logic              D_mem_write,
  input  logic [ADDR_W-1:0] D_mem_addr,
  input  logic [LINE_W-1:0] D_mem_wdata,
  output logic [LINE_W-1:0] D_mem_rdata,
  output logic              D_mem_ready,
  input  logic              I_mem_read,
  input  logic              I_mem_write,
  input  logic [ADDR_W-1:0] I_mem_addr,
  input  logic [LINE_W-1:0] I_mem_wdata,
  output logic [LINE_W-1:0] I_mem_rdata,
  output logic              I_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       d_grant_cnt,
  output logic [31:0]       i_grant_cnt,
  output logic [31:0]       conflict_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BUSY_D = 3'd1,
    S_BUSY_I = 3'd2,
    S_DONE_D = 3'd3,
    S_DONE_I = 3'd4
  } state_t;

  localparam logic c_fixed_prio = (FIXED_PRIO != 0);

  state_t r_state;
  logic   r_last_grant_i;
  logic   w_d_valid;
  logic   w_i_valid;
  logic   w_grant_d;
  logic   w_grant_i;

  // Read and write together is treated as no request at all.
  assign w_d_valid = D_mem_read ^ D_mem_write;
  assign w_i_valid = I_mem_read ^ I_mem_write;
  assign w_grant_d = w_d_valid & (~w_i_valid | c_fixed_prio | r_last_grant_i);
  assign w_grant_i = w_i_valid & ~w_grant_d;

  // The mem_* outputs double as the latched request registers.
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      r_state        <= S_IDLE;
      r_last_grant_i <= 1'b1;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      D_mem_ready    <= 1'b0;
      I_mem_ready    <= 1'b0;
      D_mem_rdata    <= '0;
      I_mem_rdata    <= '0;
    end else begin
      D_mem_ready <= 1'b0;
      I_mem_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_state        <= S_BUSY_D;
            r_last_grant_i <= 1'b0;
            mem_read       <= D_mem_read;
            mem_write      <= D_mem_write;
            mem_addr       <= D_mem_addr;
            mem_wdata      <= D_mem_wdata;
          end else if (w_grant_i) begin
            r_state        <= S_BUSY_I;
            r_last_grant_i <= 1'b1;
            mem_read       <= I_mem_read;
            mem_write      <= I_mem_write;
            mem_addr       <= I_mem_addr;
            mem_wdata      <= I_mem_wdata;
          end
        end
        S_BUSY_D: begin
          if (mem_ready) begin
            r_state     <= S_DONE_D;
            D_mem_ready <= 1'b1;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            if (mem_read) D_mem_rdata <= mem_rdata;
          end
        end
        S_BUSY_I: begin
          if (mem_ready) begin
            r_state     <= S_DONE_I;
            I_mem_ready <= 1'b1;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            if (mem_read) I_mem_rdata <= mem_rdata;
          end
        end
        S_DONE_D, S_DONE_I: r_state <= S_IDLE;
        default:            r_state <= S_IDLE;
      endcase
    end
  end

`ifdef L2_ARB_PERF_CNT_EN
  logic [31:0] r_d_grant_cnt;
  logic [31:0] r_i_grant_cnt;
  logic [31:0] r_conflict_cnt;

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      r_d_grant_cnt  <= '0;
      r_i_grant_cnt  <= '0;
      r_conflict_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_grant_d)             r_d_grant_cnt  <= r_d_grant_cnt + 32'd1;
      if (w_grant_i)             r_i_grant_cnt  <= r_i_grant_cnt + 32'd1;
      if (w_d_valid & w_i_valid) r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign d_grant_cnt  = r_d_grant_cnt;
  assign i_grant_cnt  = r_i_grant_cnt;
  assign conflict_cnt = r_conflict_cnt;
`else
  assign d_grant_cnt  = 32'd0;
  assign i_grant_cnt  = 32'd0;
  assign conflict_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_l2_mem_arbiter.sv
// ------------------------------------------------------------------
// tb_l2_mem_arbiter: directed vectors for round-robin and fixed-priority
// builds of l2_mem_arbiter, with a fixed-latency memory responder. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_l2_mem_arbiter;

  localparam int AW = 28;
  localparam int LW = 128;
  localparam logic [LW-1:0] D_WD = {32{4'hD}};
  localparam logic [LW-1:0] I_WD = {32{4'hE}};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          d_rd = 1'b0, d_wr = 1'b0, i_rd = 1'b0, i_wr = 1'b0;
  logic [AW-1:0] d_addr = '0, i_addr = '0;
  logic [LW-1:0] d_wdata = D_WD, i_wdata = I_WD, m_rdata = '0;

  logic [LW-1:0] rr_d_rdata, rr_i_rdata, rr_mwdata, fp_d_rdata, fp_i_rdata, fp_mwdata;
  logic          rr_d_ready, rr_i_ready, rr_mrd, rr_mwr, rr_mrdy;
  logic          fp_d_ready, fp_i_ready, fp_mrd, fp_mwr, fp_mrdy;
  logic [AW-1:0] rr_maddr, fp_maddr;
  logic [31:0]   rr_dcnt, rr_icnt, rr_ccnt, fp_dcnt, fp_icnt, fp_ccnt;
  int            rr_cnt, fp_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  l2_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .proc_reset_n(rst_n),
    .D_mem_read(d_rd), .D_mem_write(d_wr), .D_mem_addr(d_addr), .D_mem_wdata(d_wdata),
    .D_mem_rdata(rr_d_rdata), .D_mem_ready(rr_d_ready),
    .I_mem_read(i_rd), .I_mem_write(i_wr), .I_mem_addr(i_addr), .I_mem_wdata(i_wdata),
    .I_mem_rdata(rr_i_rdata), .I_mem_ready(rr_i_ready),
    .mem_read(rr_mrd), .mem_write(rr_mwr), .mem_addr(rr_maddr), .mem_wdata(rr_mwdata),
    .mem_rdata(m_rdata), .mem_ready(rr_mrdy),
    .d_grant_cnt(rr_dcnt), .i_grant_cnt(rr_icnt), .conflict_cnt(rr_ccnt)
  );

  l2_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .proc_reset_n(rst_n),
    .D_mem_read(d_rd), .D_mem_write(d_wr), .D_mem_addr(d_addr), .D_mem_wdata(d_wdata),
    .D_mem_rdata(fp_d_rdata), .D_mem_ready(fp_d_ready),
    .I_mem_read(i_rd), .I_mem_write(i_wr), .I_mem_addr(i_addr), .I_mem_wdata(i_wdata),
    .I_mem_rdata(fp_i_rdata), .I_mem_ready(fp_i_ready),
    .mem_read(fp_mrd), .mem_write(fp_mwr), .mem_addr(fp_maddr), .mem_wdata(fp_mwdata),
    .mem_rdata(m_rdata), .mem_ready(fp_mrdy),
    .d_grant_cnt(fp_dcnt), .i_grant_cnt(fp_icnt), .conflict_cnt(fp_ccnt)
  );

  // Memory model: mem_ready rises on the third cycle a strobe is held.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_mrdy <= 1'b0; rr_cnt <= 0;
    end else if ((rr_mrd | rr_mwr) && !rr_mrdy) begin
      if (rr_cnt == 1) begin rr_mrdy <= 1'b1; rr_cnt <= 0; end
      else rr_cnt <= rr_cnt + 1;
    end else rr_mrdy <= 1'b0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fp_mrdy <= 1'b0; fp_cnt <= 0;
    end else if ((fp_mrd | fp_mwr) && !fp_mrdy) begin
      if (fp_cnt == 1) begin fp_mrdy <= 1'b1; fp_cnt <= 0; end
      else fp_cnt <= fp_cnt + 1;
    end else fp_mrdy <= 1'b0;
  end

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drop_all();
    d_rd = 1'b0; d_wr = 1'b0; i_rd = 1'b0; i_wr = 1'b0;
  endtask

  // Waits at negedges for a rr ready pulse; optionally checks the held strobe.
  task automatic wait_rr(input bit chk_en, input logic ewr, input logic [AW-1:0] eaddr,
                         output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rr_d_ready || rr_i_ready) begin lat = n; return; end
      if (chk_en) begin
        chk("busy_read", rr_mrd, !ewr);
        chk("busy_write", rr_mwr, ewr);
        chk("busy_addr", rr_maddr, eaddr);
      end
    end
    chk("ready_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drop_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic dr, dw; logic [AW-1:0] da;
    logic ir, iw; logic [AW-1:0] ia;
    logic [LW-1:0] rdata;
    int side;                 // 0 none, 1 D, 2 I
    logic ewr; logic [AW-1:0] eaddr;
  } vec_t;

  function automatic vec_t mk(logic dr, logic dw, logic [AW-1:0] da, logic ir, logic iw,
                              logic [AW-1:0] ia, logic [LW-1:0] rd, int side, logic ewr,
                              logic [AW-1:0] ea);
    vec_t v;
    v.dr = dr; v.dw = dw; v.da = da; v.ir = ir; v.iw = iw; v.ia = ia;
    v.rdata = rd; v.side = side; v.ewr = ewr; v.eaddr = ea;
    return v;
  endfunction

  vec_t vecs[8];
  logic [LW-1:0] exp_d_rdata, exp_i_rdata;
  int lat, dp, ip;
  logic [31:0] exp_cnt;

  initial begin
    // Round-robin DUT; last_grant starts at I after reset.
    vecs[0] = mk(1,0,28'h0000123, 0,0,28'h0,       {16{8'hA5}},   1, 0, 28'h0000123);
    vecs[1] = mk(0,1,28'h0000055, 1,0,28'h0000077, {16{8'h5A}},   2, 0, 28'h0000077);
    vecs[2] = mk(0,1,28'h0000055, 1,0,28'h0000078, {16{8'h11}},   1, 1, 28'h0000055);
    vecs[3] = mk(0,0,28'h0,       0,1,28'h0000099, {16{8'h22}},   2, 1, 28'h0000099);
    vecs[4] = mk(1,1,28'h0000040, 0,0,28'h0,       {16{8'h33}},   0, 0, 28'h0);
    vecs[5] = mk(1,1,28'h0000041, 1,0,28'h000003A, {8{16'h0123}}, 2, 0, 28'h000003A);
    vecs[6] = mk(1,0,28'hFFFFFFF, 1,1,28'h0000042, {LW{1'b1}},    1, 0, 28'hFFFFFFF);
    vecs[7] = mk(1,0,28'h0000010, 1,0,28'h0000020, {16{8'h77}},   2, 0, 28'h0000020);

    #1;
    chk("rst_mem_read", rr_mrd, 1'b0);
    chk("rst_mem_write", rr_mwr, 1'b0);
    chk("rst_mem_addr", rr_maddr, '0);
    chk("rst_ready", {rr_d_ready, rr_i_ready, fp_d_ready, fp_i_ready}, 4'b0);
    chk("rst_rdata", rr_d_rdata | rr_i_rdata, '0);
    chk("rst_cnt", {rr_dcnt, rr_icnt, rr_ccnt}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_d_rdata = '0; exp_i_rdata = '0;

    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      d_rd = vecs[k].dr; d_wr = vecs[k].dw; d_addr = vecs[k].da;
      i_rd = vecs[k].ir; i_wr = vecs[k].iw; i_addr = vecs[k].ia;
      m_rdata = vecs[k].rdata;
      if (vecs[k].side == 0) begin
        repeat (3) @(negedge clk);
        chk("nogrant_strobe", {rr_mrd, rr_mwr, rr_d_ready, rr_i_ready}, 4'b0);
        drop_all();
        @(negedge clk);
      end else begin
        @(posedge clk); #1;
        drop_all();
        chk("grant_wdata", rr_mwdata, vecs[k].ewr ? ((vecs[k].side == 1) ? D_WD : I_WD) : rr_mwdata);
        wait_rr(1'b1, vecs[k].ewr, vecs[k].eaddr, lat);
        chk("latency", lat, 4);
        chk("ready_d", rr_d_ready, vecs[k].side == 1);
        chk("ready_i", rr_i_ready, vecs[k].side == 2);
        chk("done_strobe", {rr_mrd, rr_mwr}, 2'b0);
        if (!vecs[k].ewr && vecs[k].side == 1) exp_d_rdata = vecs[k].rdata;
        if (!vecs[k].ewr && vecs[k].side == 2) exp_i_rdata = vecs[k].rdata;
        @(negedge clk);
        chk("pulse_end", {rr_d_ready, rr_i_ready}, 2'b0);
        chk("d_rdata_held", rr_d_rdata, exp_d_rdata);
        chk("i_rdata_held", rr_i_rdata, exp_i_rdata);
      end
    end

    // Held collision after reset: D write first, then I read.
    do_reset();
    d_wr = 1'b1; d_addr = 28'h55; i_rd = 1'b1; i_addr = 28'h66;
    m_rdata = {4{32'h1357_9BDF}};
    @(posedge clk); #1;
    chk("coll_d_write", {rr_mrd, rr_mwr}, 2'b01);
    chk("coll_d_addr", rr_maddr, 28'h55);
    chk("coll_d_wdata", rr_mwdata, D_WD);
    wait_rr(1'b0, 1'b0, '0, lat);
    chk("coll_d_ready", {rr_d_ready, rr_i_ready}, 2'b10);
    @(negedge clk);
    chk("coll_idle", {rr_mrd, rr_mwr}, 2'b00);
    @(negedge clk);
    chk("coll_i_read", {rr_mrd, rr_mwr}, 2'b10);
    chk("coll_i_addr", rr_maddr, 28'h66);
    drop_all();
    wait_rr(1'b0, 1'b0, '0, lat);
    chk("coll_i_ready", {rr_d_ready, rr_i_ready}, 2'b01);
    @(negedge clk);
    chk("coll_i_rdata", rr_i_rdata, {4{32'h1357_9BDF}});
    chk("coll_d_rdata_kept", rr_d_rdata, '0);

    // Address change during BUSY_D is ignored; stale DONE inputs not sampled.
    d_rd = 1'b1; d_addr = 28'h10;
    @(posedge clk); #1;
    d_addr = 28'h20;
    wait_rr(1'b1, 1'b0, 28'h10, lat);
    chk("addr_hold_lat", lat, 4);
    @(negedge clk);
    drop_all();
    @(negedge clk);
    chk("stale_done_nogrant", {rr_mrd, rr_mwr}, 2'b00);

    // Asynchronous reset mid-BUSY_I.
    i_rd = 1'b1; i_addr = 28'h44;
    @(posedge clk); #1;
    drop_all();
    chk("busy_i_strobe", rr_mrd, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_strobe", {rr_mrd, rr_mwr, rr_d_ready, rr_i_ready}, 4'b0);
    chk("arst_addr", rr_maddr, '0);
    chk("arst_rdata", rr_d_rdata | rr_i_rdata, '0);
    @(negedge clk);
    rst_n = 1'b1;
    d_rd = 1'b1; d_addr = 28'h21;
    @(posedge clk); #1;
    drop_all();
    chk("post_rst_grant", {rr_mrd, rr_mwr}, 2'b10);
    chk("post_rst_addr", rr_maddr, 28'h21);
    wait_rr(1'b0, 1'b0, '0, lat);
    chk("post_rst_ready", {rr_d_ready, rr_i_ready}, 2'b10);

    // Fixed priority: both held, D wins every arbitration.
    do_reset();
    d_rd = 1'b1; d_addr = 28'h30; i_rd = 1'b1; i_addr = 28'h31;
    dp = 0; ip = 0;
    for (int n = 0; n < 80 && dp < 3; n++) begin
      @(negedge clk);
      if (fp_d_ready) dp++;
      if (fp_i_ready) ip++;
    end
    chk("fp_d_grants", dp, 3);
    chk("fp_i_grants", ip, 0);
`ifdef L2_ARB_PERF_CNT_EN
    exp_cnt = 32'd3;
`else
    exp_cnt = 32'd0;
`endif
    chk("fp_conflict_cnt", fp_ccnt, exp_cnt);
    chk("fp_d_cnt", fp_dcnt, exp_cnt);
    chk("fp_i_cnt", fp_icnt, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("cnt_after_rst", {fp_dcnt, fp_icnt, fp_ccnt}, '0);
    drop_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
